// File: rtl/trail_compositor.sv
// Frame compositor: merges trail, sprite and crash layers per pixel and runs a
// once-per-frame look-ahead collision probe that shares the frame-buffer read port.
module trail_compositor #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned CELL_SHIFT  = 2,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [3:0]  BG_COLOR    = 4'h0,
  parameter logic [3:0]  TRANSPARENT = 4'hF,
  parameter logic [3:0]  CRASH_COLOR = 4'h7
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_clk,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [10*NUM_PLAYERS-1:0]   head_x,
  input  logic [10*NUM_PLAYERS-1:0]   head_y,
  input  logic [2*NUM_PLAYERS-1:0]    dir,
  input  logic [3:0]                  sprite_color,
  input  logic                        clear_crash,
  input  logic [15:0]                 ram_rdata,
  output logic [ADDR_W-1:0]           ram_raddr,
  output logic [3:0]                  color_enum,
  output logic [NUM_PLAYERS-1:0]      crashed,
  output logic                        probe_busy,
  output logic                        probe_done
);

  localparam int unsigned KW   = $clog2(NUM_PLAYERS + 1);
  localparam int unsigned CW   = 11;
  localparam int unsigned PW   = CW + CELL_SHIFT + 1;
  localparam int unsigned HALF = (CELL_SHIFT == 0) ? 0 : (1 << (CELL_SHIFT - 1));
  localparam logic signed [PW-1:0] H_LIM = PW'(H_RES);
  localparam logic signed [PW-1:0] V_LIM = PW'(V_RES);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  state_t                 r_state;
  logic [KW-1:0]          r_k;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_fc_cur;
  logic                   r_fc_prev;
  logic                   r_s1_valid;
  logic                   r_s1_px0;
  logic [3:0]             r_s1_sprite;
  logic [3:0]             r_color;
  logic [NUM_PLAYERS-1:0] r_crashed;

  logic signed [CW-1:0]   w_cx    [NUM_PLAYERS];
  logic signed [CW-1:0]   w_cy    [NUM_PLAYERS];
  logic signed [PW-1:0]   w_px    [NUM_PLAYERS];
  logic signed [PW-1:0]   w_py    [NUM_PLAYERS];
  logic [ADDR_W-1:0]      w_paddr [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_oob;
  logic [NUM_PLAYERS-1:0] w_headon;
  logic [NUM_PLAYERS-1:0] w_set;
  logic [3:0]             w_trail;
  logic                   w_rise;
  logic                   w_unused;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [31:0] px, input logic [31:0] py);
    return ADDR_W'((px >> 1) + py * 32'(H_RES / 2));
  endfunction

  // Look-ahead cell, its pixel centre, wall test and frame-buffer address per player
  always_comb begin
    logic signed [CW-1:0] dx;
    logic signed [CW-1:0] dy;
    dx       = '0;
    dy       = '0;
    w_headon = '0;
    w_oob    = '0;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      dx = '0;
      dy = '0;
      case (dir[2*i +: 2])
        2'b00:   dy = '1;
        2'b01:   dy = CW'(1);
        2'b10:   dx = '1;
        default: dx = CW'(1);
      endcase
      w_cx[i]    = $signed({1'b0, head_x[10*i +: 10]}) + dx;
      w_cy[i]    = $signed({1'b0, head_y[10*i +: 10]}) + dy;
      w_px[i]    = (PW'(w_cx[i]) <<< CELL_SHIFT) + $signed(PW'(HALF));
      w_py[i]    = (PW'(w_cy[i]) <<< CELL_SHIFT) + $signed(PW'(HALF));
      w_oob[i]   = w_cx[i][CW-1] || w_cy[i][CW-1] || (w_px[i] >= H_LIM) || (w_py[i] >= V_LIM);
      w_paddr[i] = f_addr(32'(w_px[i]), 32'(w_py[i]));
    end
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      for (int j = 0; j < int'(NUM_PLAYERS); j++) begin
        if ((i != j) && (w_cx[i] == w_cx[j]) && (w_cy[i] == w_cy[j])) w_headon[i] = 1'b1;
      end
    end
  end

  // Player k-1 is judged on the read data returned for the address issued last cycle
  always_comb begin
    logic [3:0] nib;
    nib   = '0;
    w_set = '0;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      nib      = w_px[i][0] ? ram_rdata[11:8] : ram_rdata[3:0];
      w_set[i] = (r_state == S_PROBE) && (r_k == KW'(i + 1)) &&
                 (w_oob[i] || w_headon[i] || (nib != BG_COLOR));
    end
  end

  // Read-port arbitration: the probe owns the port while busy
  always_comb begin
    ram_raddr = f_addr(32'(DrawX), 32'(DrawY));
    if (Reset) begin
      ram_raddr = '0;
    end else if (r_busy) begin
      ram_raddr = '0;
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        if (r_k == KW'(i)) ram_raddr = w_paddr[i];
      end
    end
  end

  assign w_rise   = r_fc_cur & ~r_fc_prev;
  assign w_trail  = r_s1_valid ? (r_s1_px0 ? ram_rdata[11:8] : ram_rdata[3:0]) : BG_COLOR;
  assign w_unused = &{1'b0, ram_rdata[15:12], ram_rdata[7:4]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fc_cur    <= 1'b0;
      r_fc_prev   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_px0    <= 1'b0;
      r_s1_sprite <= '0;
      r_color     <= '0;
      r_crashed   <= '0;
    end else begin
      r_fc_cur    <= frame_clk;
      r_fc_prev   <= r_fc_cur;
      r_s1_valid  <= ~r_busy;
      r_s1_px0    <= DrawX[0];
      r_s1_sprite <= sprite_color;
      if (|r_crashed)                      r_color <= CRASH_COLOR;
      else if (r_s1_sprite != TRANSPARENT) r_color <= r_s1_sprite;
      else                                 r_color <= w_trail;
      // A fresh hit outranks a simultaneous clear for its own bit
      r_crashed   <= (r_crashed & ~{NUM_PLAYERS{clear_crash}}) | w_set;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_PROBE;
            r_k     <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_PROBE: begin
          if (r_k == KW'(NUM_PLAYERS)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign color_enum = r_color;
  assign crashed    = r_crashed;
  assign probe_busy = r_busy;
  assign probe_done = r_done;

endmodule

// File: tb/tb_trail_compositor.sv
// Scoreboard bench for trail_compositor: stimulus schedules expected values by
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_trail_compositor;

  localparam int K_COLOR = 0;
  localparam int K_RADDR = 1;
  localparam int K_CRASH = 2;
  localparam int K_BUSY  = 3;
  localparam int K_DONE  = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [19:0] head_x;
  logic [19:0] head_y;
  logic [3:0]  dir;
  logic [3:0]  sprite_color;
  logic        clear_crash;
  logic [15:0] ram_rdata;
  logic [18:0] ram_raddr;
  logic [3:0]  color_enum;
  logic [1:0]  crashed;
  logic        probe_busy;
  logic        probe_done;

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [int];
  int          cyc_n    = 0;
  int          checks   = 0;
  int          failures = 0;

  trail_compositor #(.NUM_PLAYERS(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .head_x       (head_x),
    .head_y       (head_y),
    .dir          (dir),
    .sprite_color (sprite_color),
    .clear_crash  (clear_crash),
    .ram_rdata    (ram_rdata),
    .ram_raddr    (ram_raddr),
    .color_enum   (color_enum),
    .crashed      (crashed),
    .probe_busy   (probe_busy),
    .probe_done   (probe_done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] rd(input logic [18:0] a);
    int k;
    k = int'(a);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  // Synchronous frame RAM: data one cycle after the address
  always @(posedge Clk) ram_rdata <= rd(ram_raddr);

  task automatic compare(input exp_t e);
    logic [31:0] act;
    act = '0;
    case (e.kind)
      K_COLOR: act = 32'(color_enum);
      K_RADDR: act = 32'(ram_raddr);
      K_CRASH: act = 32'(crashed);
      K_BUSY:  act = 32'(probe_busy);
      default: act = 32'(probe_done);
    endcase
    checks++;
    if (act !== e.exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", e.nm, cyc_n, act, e.exp);
    end
  endtask

  always @(negedge Clk) begin
    cyc_n = cyc_n + 1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc_n) begin
        compare(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // dly=1 is the next negedge; a value registered m edges from now appears at dly=m+1
  task automatic exp_at(input int dly, input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.at   = cyc_n + dly;
    e.kind = kind;
    e.exp  = v;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic set_heads(input logic [9:0] x0, input logic [9:0] y0, input logic [1:0] d0,
                           input logic [9:0] x1, input logic [9:0] y1, input logic [1:0] d1);
    head_x = {x1, x0};
    head_y = {y1, y0};
    dir    = {d1, d0};
  endtask

  task automatic clear_flags();
    frame_clk   = 1'b0;
    clear_crash = 1'b1;
    exp_at(2, K_CRASH, 32'd0, "clear_crash");
    tick(1);
    clear_crash = 1'b0;
    tick(3);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    frame_clk    = 1'b0;
    DrawX        = 10'd10;
    DrawY        = 10'd3;
    sprite_color = 4'hF;
    clear_crash  = 1'b0;
    set_heads(10'd40, 10'd40, 2'b01, 10'd50, 10'd50, 2'b01);
    mem[965]   = 16'h0500;
    mem[970]   = 16'h0306;
    mem[39083] = 16'h0004;

    // Reset state (pixel address would be 965 without reset)
    tick(2);
    exp_at(1, K_COLOR, 32'd0, "rst_color");
    exp_at(1, K_CRASH, 32'd0, "rst_crashed");
    exp_at(1, K_BUSY,  32'd0, "rst_busy");
    exp_at(1, K_DONE,  32'd0, "rst_done");
    exp_at(1, K_RADDR, 32'd0, "rst_raddr");
    tick(1);
    Reset = 1'b0;

    // Pixel path: address map, nibble select, sprite priority
    exp_at(1, K_RADDR, 32'd965, "pix_addr_even");
    exp_at(3, K_COLOR, 32'h0,   "pix_even_nibble");
    tick(1);
    DrawX = 10'd11;
    exp_at(1, K_RADDR, 32'd965, "pix_addr_odd");
    exp_at(3, K_COLOR, 32'h5,   "pix_odd_nibble");
    tick(1);
    DrawX = 10'd20;
    sprite_color = 4'h2;
    exp_at(1, K_RADDR, 32'd970, "pix_addr_20");
    exp_at(3, K_COLOR, 32'h2,   "sprite_over_trail");
    tick(1);
    sprite_color = 4'hF;
    exp_at(3, K_COLOR, 32'h6,   "trail_even");
    tick(1);
    DrawX = 10'd21;
    exp_at(3, K_COLOR, 32'h3,   "trail_odd");
    tick(4);

    // Probe: P0 hits a trail nibble, P1 clear
    DrawX = 10'd0;
    DrawY = 10'd0;
    sprite_color = 4'h2;
    set_heads(10'd20, 10'd30, 2'b11, 10'd50, 10'd50, 2'b01);
    frame_clk = 1'b1;
    exp_at(3, K_BUSY,  32'd1,     "probe_busy_k0");
    exp_at(3, K_RADDR, 32'd39083, "probe_addr_p0");
    exp_at(4, K_RADDR, 32'd66021, "probe_addr_p1");
    exp_at(4, K_CRASH, 32'd0,     "trail_pre_eval");
    exp_at(5, K_BUSY,  32'd1,     "probe_busy_k2");
    exp_at(5, K_DONE,  32'd0,     "done_not_early");
    exp_at(5, K_CRASH, 32'd1,     "trail_p0_crash");
    exp_at(6, K_DONE,  32'd1,     "done_pulse");
    exp_at(6, K_BUSY,  32'd0,     "busy_off_done");
    exp_at(6, K_CRASH, 32'd1,     "trail_p1_clear");
    exp_at(7, K_DONE,  32'd0,     "done_one_cycle");
    exp_at(8, K_COLOR, 32'h7,     "crash_override");
    tick(10);
    sprite_color = 4'hF;
    clear_flags();

    // Walls: P0 past right edge, P1 past left edge
    set_heads(10'd159, 10'd10, 2'b11, 10'd0, 10'd5, 2'b10);
    frame_clk = 1'b1;
    exp_at(5, K_CRASH, 32'd1, "wall_right_p0");
    exp_at(6, K_CRASH, 32'd3, "wall_left_p1");
    exp_at(6, K_DONE,  32'd1, "wall_done");
    tick(10);
    clear_flags();

    // Head-on: both look-ahead cells at (11,10)
    set_heads(10'd10, 10'd10, 2'b11, 10'd12, 10'd10, 2'b10);
    frame_clk = 1'b1;
    exp_at(5, K_CRASH, 32'd1, "headon_p0");
    exp_at(6, K_CRASH, 32'd3, "headon_both");
    tick(10);
    clear_flags();

    // Second edge mid-pass ignored; pixels issued while busy read as background
    set_heads(10'd40, 10'd40, 2'b01, 10'd50, 10'd50, 2'b01);
    DrawX = 10'd11;
    DrawY = 10'd3;
    frame_clk = 1'b1;
    exp_at(3, K_BUSY,  32'd1, "dbl_busy");
    exp_at(3, K_COLOR, 32'h5, "pix_pre_probe");
    exp_at(5, K_COLOR, 32'h0, "pix_blanked");
    exp_at(5, K_DONE,  32'd0, "dbl_done_early");
    exp_at(6, K_DONE,  32'd1, "dbl_done_pulse");
    exp_at(8, K_COLOR, 32'h5, "pix_post_probe");
    exp_at(8, K_CRASH, 32'd0, "dbl_no_crash");
    for (int d = 7; d <= 12; d++) begin
      exp_at(d, K_DONE, 32'd0, "dbl_single_done");
      exp_at(d, K_BUSY, 32'd0, "dbl_no_restart");
    end
    tick(1);
    frame_clk = 1'b0;
    tick(1);
    frame_clk = 1'b1;
    tick(12);
    frame_clk = 1'b0;
    tick(3);

    // Reset during PROBE k=1 aborts before P0's wall hit lands
    set_heads(10'd159, 10'd10, 2'b11, 10'd50, 10'd50, 2'b01);
    frame_clk = 1'b1;
    exp_at(4, K_BUSY,  32'd1, "abort_busy_k1");
    exp_at(4, K_RADDR, 32'd0, "abort_raddr_rst");
    exp_at(5, K_BUSY,  32'd0, "abort_busy_off");
    exp_at(5, K_CRASH, 32'd0, "abort_crashed");
    exp_at(7, K_CRASH, 32'd0, "abort_crashed_late");
    for (int d = 5; d <= 10; d++) exp_at(d, K_DONE, 32'd0, "abort_no_done");
    tick(3);
    Reset     = 1'b1;
    frame_clk = 1'b0;
    tick(1);
    Reset = 1'b0;
    tick(10);

    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s never_sampled at=%0d required=%0h", sb[i].nm, sb[i].at, sb[i].exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
